// File: rtl/dds_cfg_sched.sv
// Two-requester configuration scheduler for the dual-channel DDS: round-robin grant, shadow
// staging, and commit to the active words on a sync tick or after a bounded wait.
module dds_cfg_sched #(
  parameter int unsigned DW      = 32,
  parameter int unsigned PW      = 12,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req0_i,
  input  logic          req1_i,
  input  logic [1:0]    sel0_i,
  input  logic [1:0]    sel1_i,
  input  logic [DW-1:0] data0_i,
  input  logic [DW-1:0] data1_i,
  input  logic          sync_i,
  output logic          ack0_o,
  output logic          ack1_o,
  output logic [DW-1:0] f1_word_o,
  output logic [DW-1:0] f2_word_o,
  output logic [PW-1:0] p1_word_o,
  output logic [PW-1:0] p2_word_o,
  output logic [1:0]    c_flag_o,
  output logic          upd_o,
  output logic          busy_o,
  output logic          tmo_o
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StWaitSync} state_e;

  state_e        state_q;
  logic          rr_q;
  logic          gnt1_q;
  logic [1:0]    sel_q;
  logic [DW-1:0] data_q;
  logic [1:0]    pend_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] sh_f1_q, sh_f2_q, f1_q, f2_q;
  logic [PW-1:0] sh_p1_q, sh_p2_q, p1_q, p2_q;
  logic [1:0]    c_flag_q;
  logic          ack0_q, ack1_q, upd_q, busy_q, tmo_q;
  logic          grant1;
  logic          expire;

  // Pointer set means requester 1 is favoured when both request.
  always_comb begin
    grant1 = req1_i & (~req0_i | rr_q);
    expire = (cnt_q == CntLast);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      rr_q     <= 1'b0;
      gnt1_q   <= 1'b0;
      sel_q    <= '0;
      data_q   <= '0;
      pend_q   <= '0;
      cnt_q    <= '0;
      sh_f1_q  <= '0;
      sh_f2_q  <= '0;
      sh_p1_q  <= '0;
      sh_p2_q  <= '0;
      f1_q     <= '0;
      f2_q     <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      c_flag_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      upd_q    <= 1'b0;
      busy_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      upd_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req0_i || req1_i) begin
            gnt1_q  <= grant1;
            sel_q   <= grant1 ? sel1_i : sel0_i;
            data_q  <= grant1 ? data1_i : data0_i;
            rr_q    <= ~grant1;
            ack0_q  <= ~grant1;
            ack1_q  <= grant1;
            busy_q  <= 1'b1;
            state_q <= StWrite;
          end
        end
        StWrite: begin
          unique case (sel_q)
            2'd0: sh_f1_q <= data_q;
            2'd1: sh_p1_q <= data_q[PW-1:0];
            2'd2: sh_f2_q <= data_q;
            2'd3: sh_p2_q <= data_q[PW-1:0];
            default: ;
          endcase
          pend_q  <= sel_q;
          cnt_q   <= '0;
          state_q <= StWaitSync;
        end
        StWaitSync: begin
          cnt_q <= cnt_q + CW'(1);
          if (sync_i || expire) begin
            f1_q     <= sh_f1_q;
            f2_q     <= sh_f2_q;
            p1_q     <= sh_p1_q;
            p2_q     <= sh_p2_q;
            c_flag_q <= pend_q;
            upd_q    <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
            // A coincident sync makes the commit a normal one.
            if (!sync_i) tmo_q <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    ack0_o    = ack0_q;
    ack1_o    = ack1_q;
    f1_word_o = f1_q;
    f2_word_o = f2_q;
    p1_word_o = p1_q;
    p2_word_o = p2_q;
    c_flag_o  = c_flag_q;
    upd_o     = upd_q;
    busy_o    = busy_q;
    tmo_o     = tmo_q;
  end

endmodule

// File: tb/tb_dds_cfg_sched.sv
// Bench for dds_cfg_sched: directed and random requests, with a transaction-level model that
// predicts grants and commit cycles and a negedge monitor that scores every output.
module tb_dds_cfg_sched;
  localparam int unsigned DW  = 32;
  localparam int unsigned PW  = 12;
  localparam int unsigned TMO = 8;

  logic          clk = 1'b0, rst = 1'b1, sync = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [1:0]    sel0 = '0, sel1 = '0;
  logic [DW-1:0] data0 = '0, data1 = '0;
  logic          ack0, ack1, upd, busy, tmo;
  logic [DW-1:0] f1, f2;
  logic [PW-1:0] p1, p2;
  logic [1:0]    c_flag;

  dds_cfg_sched #(.DW(DW), .PW(PW), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .req0_i(req0), .req1_i(req1), .sel0_i(sel0), .sel1_i(sel1),
    .data0_i(data0), .data1_i(data1), .sync_i(sync), .ack0_o(ack0), .ack1_o(ack1),
    .f1_word_o(f1), .f2_word_o(f2), .p1_word_o(p1), .p2_word_o(p2), .c_flag_o(c_flag),
    .upd_o(upd), .busy_o(busy), .tmo_o(tmo)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int sync_pct = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (sync_pct > 0) begin
      #1;
      sync = ($urandom_range(0, 99) < sync_pct);
    end
  end

  // Reference model: each grant leads to one commit, either on the first sampled sync of the
  // wait window or on its TMO-th cycle; committed words land in a four-entry register file.
  typedef struct {int cyc; logic [1:0] sel; logic [31:0] data; bit forced;} commit_t;
  commit_t     exp_q[$];
  int          cyc = 0, trk_k = 0;
  bit          m_idle = 1, trk = 0, exp_ack = 0, m_ptr = 0, m_win = 0, m_tmo = 0;
  logic [1:0]  g_sel, m_cflag;
  logic [31:0] g_data;
  logic [31:0] m_act[4];
  commit_t     c;
  bit          eu;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_idle = 1; trk = 0; exp_ack = 0; m_ptr = 0; m_tmo = 0; m_cflag = '0;
      for (int i = 0; i < 4; i++) m_act[i] = '0;
      exp_q.delete();
    end else begin
      eu = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("upd", upd, eu);
      if (eu) begin
        c = exp_q.pop_front();
        m_act[c.sel] = c.sel[0] ? (c.data & ((32'd1 << PW) - 1)) : c.data;
        m_cflag = c.sel;
        m_tmo   = m_tmo | c.forced;
        m_idle  = 1;
      end
      if (trk) begin
        if (sync || trk_k == int'(TMO) - 1) begin
          exp_q.push_back('{cyc + 1, g_sel, g_data, !sync});
          trk = 0;
        end else trk_k++;
      end
      chk("ack0", ack0, exp_ack && !m_win);
      chk("ack1", ack1, exp_ack && m_win);
      if (exp_ack) begin
        exp_ack = 0; trk = 1; trk_k = 0;
      end
      chk("busy", busy, !m_idle);
      chk("f1", f1, m_act[0]);
      chk("p1", p1, m_act[1]);
      chk("f2", f2, m_act[2]);
      chk("p2", p2, m_act[3]);
      chk("c_flag", c_flag, m_cflag);
      chk("tmo", tmo, m_tmo);
      if (m_idle && (req0 || req1)) begin
        m_win   = (req0 && req1) ? m_ptr : req1;
        m_ptr   = !m_win;
        g_sel   = m_win ? sel1 : sel0;
        g_data  = m_win ? data1 : data0;
        exp_ack = 1;
        m_idle  = 0;
      end
    end
  end

  task automatic set_req(input int i, input logic r, input logic [1:0] s, input logic [31:0] d);
    if (i == 0) begin req0 = r; sel0 = s; data0 = d; end
    else        begin req1 = r; sel1 = s; data1 = d; end
  endtask

  task automatic issue(input int i, input logic [1:0] s, input logic [31:0] d, input bit keep);
    int  n;
    bit  got;
    @(posedge clk); #1;
    set_req(i, 1'b1, s, d);
    n = 0; got = 0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      got = (i == 0) ? ack0 : ack1;
    end
    chk("ack_wait", got, 1);
    if (!keep) begin
      @(posedge clk); #1;
      if (i == 0) req0 = 1'b0; else req1 = 1'b0;
    end
  endtask

  task automatic pulse_sync(input int delay);
    repeat (delay) @(posedge clk);
    #1 sync = 1'b1;
    @(posedge clk); #1 sync = 1'b0;
  endtask

  task automatic wait_upd();
    int n;
    bit got;
    n = 0; got = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      got = upd;
    end
    chk("upd_wait", got, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_f1", f1, 0);
    chk("rst_acks", {ack1, ack0}, 0);
    chk("rst_upd", upd, 0);
    chk("rst_tmo", tmo, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single write with sync three cycles after ack
    issue(0, 2'd0, 32'h1234_5678, 0);
    pulse_sync(2);
    wait_upd();
    chk("single_f1", f1, 32'h1234_5678);
    chk("single_cflag", c_flag, 0);
    chk("single_tmo", tmo, 0);

    // Phase truncation
    issue(1, 2'd3, 32'hFFFF_ABCD, 0);
    pulse_sync(1);
    wait_upd();
    chk("trunc_p2", p2, 12'hBCD);
    chk("trunc_cflag", c_flag, 3);

    // Timeout, then tmo stays set across a normal write
    issue(1, 2'd2, $urandom, 0);
    wait_upd();
    chk("tmo_set", tmo, 1);
    issue(0, 2'd1, $urandom, 0);
    pulse_sync(0);
    wait_upd();
    chk("tmo_sticky", tmo, 1);

    // Reset in WAIT_SYNC discards the pending write
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    issue(0, 2'd1, 32'h0000_0055, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    pulse_sync(1);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("midrst_p1", p1, 0);
    chk("midrst_busy", busy, 0);

    // Arbitration: both requests held from reset, sync every cycle
    @(posedge clk); #1;
    rst = 1'b1;
    set_req(0, 1'b1, 2'd0, $urandom);
    set_req(1, 1'b1, 2'd2, $urandom);
    sync_pct = 100;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    fork
      for (int k = 0; k < 4; k++) issue(0, 2'(k), $urandom, k < 3);
      for (int k = 0; k < 4; k++) issue(1, 2'(3 - k), $urandom, k < 3);
    join

    // Random traffic with random sync density
    sync_pct = 30;
    fork
      for (int k = 0; k < 15; k++) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        issue(0, 2'($urandom_range(0, 3)), $urandom, bit'($urandom_range(0, 1)));
      end
      for (int k = 0; k < 15; k++) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        issue(1, 2'($urandom_range(0, 3)), $urandom, bit'($urandom_range(0, 1)));
      end
    join
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
    sync_pct = 0;
    @(posedge clk); #2 sync = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("drain_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
